uart_tx_arbiter: RTL and testbench

Shares one UART transmitter (8-bit DataIn/DataInValid/DataInReady byte interface) among NumPorts byte-stream requesters. Arbitration is round-robin at message granularity. A grant holds until the requester's Last-flagged byte is accepted. Optionally inserts a per-port header byte before each message, and releases a stalled requester after an idle timeout.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding, header/timeout defaults and the common log2 helper.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } arb_state_e;

   localparam logic [7:0] HEADER_BASE_DEFAULT  = 8'hF0;
   localparam int         IDLE_TIMEOUT_DEFAULT = 1024;

   // Ceiling log2; a value of 1 yields 0.
   function automatic int arb_log2(input int value);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request-side byte streams plus the transmitter-side byte interface and status.
// master = arbiter, slave = requesters/transmitter/observer.
interface uart_tx_arbiter_if #(
   parameter int NumPorts    = 4,
   parameter int PortIdWidth = 2
);
   logic [8*NumPorts-1:0] ReqData;
   logic [NumPorts-1:0]   ReqValid;
   logic [NumPorts-1:0]   ReqLast;
   logic [NumPorts-1:0]   ReqReady;
   logic [7:0]            TxData;
   logic                  TxValid;
   logic                  TxReady;
   logic [PortIdWidth-1:0] Grant;
   logic                  Busy;
   logic                  Abort;

   modport master (
      input  ReqData, ReqValid, ReqLast, TxReady,
      output ReqReady, TxData, TxValid, Grant, Busy, Abort
   );

   modport slave (
      output ReqData, ReqValid, ReqLast, TxReady,
      input  ReqReady, TxData, TxValid, Grant, Busy, Abort
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, with wrap.
// Reusable by any arbiter that keeps its own last-grant register.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NumPorts    = 4,
   parameter int PortIdWidth = arb_log2(NumPorts)
) (
   input  logic [NumPorts-1:0]    req,
   input  logic [PortIdWidth-1:0] last_grant,
   output logic [PortIdWidth-1:0] winner,
   output logic                   any_req
);

   logic [PortIdWidth-1:0] cand;

   // Scan from farthest to nearest so the nearest valid port overwrites last.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      winner  = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int i = NumPorts; i >= 1; i--) begin
         cand = PortIdWidth'((int'(last_grant) + i) % NumPorts);
         if (req[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NumPorts byte streams, round-robin per message,
// with an optional per-port header byte and an idle-timeout release of a stalled sender.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NumPorts         = 4,
   parameter int         PortIdWidth      = arb_log2(NumPorts),
   parameter int         HeaderEnable     = 1,
   parameter logic [7:0] HeaderBase       = HEADER_BASE_DEFAULT,
   parameter int         IdleTimeout      = IDLE_TIMEOUT_DEFAULT,
   parameter int         IdleCounterWidth = arb_log2(IdleTimeout) + 1
) (
   input logic               Clock,
   input logic               Reset_n,
   uart_tx_arbiter_if.master bus
);

   arb_state_e                  state_q, state_d;
   logic [PortIdWidth-1:0]      grant_q, grant_d;
   logic [PortIdWidth-1:0]      last_grant_q, last_grant_d;
   logic [IdleCounterWidth-1:0] idle_cnt_q, idle_cnt_d;

   logic [PortIdWidth-1:0] pick_idx;
   logic                   pick_any;
   logic [NumPorts-1:0]    req_ready;
   logic [7:0]             tx_data;
   logic                   tx_valid;
   logic                   abort;
   logic                   g_valid;

   rr_pick #(
      .NumPorts    (NumPorts),
      .PortIdWidth (PortIdWidth)
   ) u_rr_pick (
      .req        (bus.ReqValid),
      .last_grant (last_grant_q),
      .winner     (pick_idx),
      .any_req    (pick_any)
   );

   assign g_valid = bus.ReqValid[grant_q];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      idle_cnt_d   = idle_cnt_q;
      tx_data      = '0;
      tx_valid     = 1'b0;
      req_ready    = '0;
      abort        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               idle_cnt_d   = '0;
               state_d      = (HeaderEnable != 0) ? ST_HEADER : ST_PAYLOAD;
            end
         end
         ST_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = HeaderBase + 8'(grant_q);
            if (bus.TxReady) begin
               idle_cnt_d = '0;
               state_d    = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            tx_data            = bus.ReqData[{grant_q, 3'b000} +: 8];
            tx_valid           = g_valid;
            req_ready[grant_q] = bus.TxReady;
            // A transfer always beats a simultaneous timeout; backpressure never counts.
            if (g_valid && bus.TxReady) begin
               idle_cnt_d = '0;
               if (bus.ReqLast[grant_q]) state_d = ST_IDLE;
            end else if (!g_valid) begin
               if (idle_cnt_q == IdleCounterWidth'(IdleTimeout)) begin
                  abort      = 1'b1;
                  idle_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= PortIdWidth'(NumPorts - 1);
         idle_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   assign bus.ReqReady = req_ready;
   assign bus.TxData   = tx_data;
   assign bus.TxValid  = tx_valid;
   assign bus.Grant    = grant_q;
   assign bus.Busy     = (state_q != ST_IDLE);
   assign bus.Abort    = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-port message queues drive the DUT and a
// message-level round-robin model predicts the transmitted byte stream and grant order.
module tb_uart_tx_arbiter;

   localparam int NP = 4;
   localparam int TO = 16;

   logic clk;
   logic rst_n;

   uart_tx_arbiter_if #(.NumPorts(NP), .PortIdWidth(2)) bus ();

   uart_tx_arbiter #(
      .NumPorts         (NP),
      .PortIdWidth      (2),
      .HeaderEnable     (1),
      .HeaderBase       (8'hF0),
      .IdleTimeout      (TO),
      .IdleCounterWidth (5)
   ) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [8:0] pmem [NP][32];
   int         head [NP];
   int         tail [NP];
   logic       rand_ready = 1'b0;
   logic [7:0] got   [256];
   int         ngot;
   logic [7:0] exp_b [256];
   int         nexp;
   int         exp_g [64];
   int         nexp_g;
   int         obs_g [64];
   int         nobs_g;
   int         model_lg;
   logic       busy_s, abort_s, prev_busy;
   logic [1:0] grant_s;
   int         abort_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic bit pending();
      bit r;
      r = 1'b0;
      for (int p = 0; p < NP; p++) if (head[p] < tail[p]) r = 1'b1;
      return r;
   endfunction

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (head[p] < tail[p]) begin
            bus.ReqValid[p]       = 1'b1;
            bus.ReqData[p*8 +: 8] = pmem[p][head[p]][7:0];
            bus.ReqLast[p]        = pmem[p][head[p]][8];
         end else begin
            bus.ReqValid[p]       = 1'b0;
            bus.ReqData[p*8 +: 8] = 8'h00;
            bus.ReqLast[p]        = 1'b0;
         end
      end
      if (rand_ready) bus.TxReady = ($urandom_range(0, 3) != 0);
   endtask

   // Sample at the falling edge, then update inputs just after the rising edge.
   task automatic step();
      @(negedge clk);
      busy_s  = bus.Busy;
      abort_s = bus.Abort;
      grant_s = bus.Grant;
      if (abort_s) abort_cnt++;
      if (busy_s && !prev_busy && nobs_g < 64) begin
         obs_g[nobs_g] = int'(grant_s);
         nobs_g++;
      end
      prev_busy = busy_s;
      if (bus.TxValid && bus.TxReady && ngot < 256) begin
         got[ngot] = bus.TxData;
         ngot++;
      end
      for (int p = 0; p < NP; p++) if (bus.ReqValid[p] && bus.ReqReady[p]) head[p]++;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic clear();
      for (int p = 0; p < NP; p++) begin
         head[p] = 0;
         tail[p] = 0;
      end
      ngot = 0; nobs_g = 0; abort_cnt = 0;
      drive();
   endtask

   task automatic add_byte(input int p, input logic [7:0] d, input logic l);
      pmem[p][tail[p]] = {l, d};
      tail[p]++;
   endtask

   task automatic add_msg(input int p, input int n);
      for (int k = 0; k < n; k++) add_byte(p, 8'($urandom), (k == n - 1));
   endtask

   // Message-level model: pick the next port after the last winner that has a message,
   // emit its header and bytes up to Last, and make it the new lowest priority.
   task automatic build_model();
      int mh [NP];
      int p;
      bit found;
      bit last;
      nexp = 0; nexp_g = 0; p = 0;
      for (int i = 0; i < NP; i++) mh[i] = head[i];
      for (int m = 0; m < 64; m++) begin
         found = 1'b0;
         for (int i = 1; i <= NP; i++) begin
            int q;
            q = (model_lg + i) % NP;
            if (!found && mh[q] < tail[q]) begin
               found = 1'b1;
               p = q;
            end
         end
         if (!found) break;
         exp_g[nexp_g] = p;
         nexp_g++;
         exp_b[nexp] = 8'(8'hF0 + p);
         nexp++;
         last = 1'b0;
         while (!last && mh[p] < tail[p]) begin
            exp_b[nexp] = pmem[p][mh[p]][7:0];
            last = pmem[p][mh[p]][8];
            nexp++;
            mh[p]++;
         end
         model_lg = p;
      end
   endtask

   task automatic run_done(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((pending() || busy_s) && n < budget);
      total++;
      if (pending() || busy_s) begin
         bad++;
         $display("FAIL drain: busy after %0d cycles, required idle", budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_lg  = NP - 1;
      prev_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.TxReady = 1'b0;
      clear();
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.Busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
      total++; if (bus.TxValid !== 1'b0)  begin bad++; $display("FAIL rst_txvalid: got %b want 0", bus.TxValid); end
      total++; if (bus.ReqReady !== 4'h0) begin bad++; $display("FAIL rst_reqready: got %h want 0", bus.ReqReady); end
      total++; if (bus.Abort !== 1'b0)    begin bad++; $display("FAIL rst_abort: got %b want 0", bus.Abort); end
      total++; if (bus.Grant !== 2'd0)    begin bad++; $display("FAIL rst_grant: got %0d want 0", bus.Grant); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_lg  = NP - 1;
      prev_busy = 1'b0;
   endtask

   task automatic test_single();
      int n;
      clear();
      bus.TxReady = 1'b1;
      add_byte(2, 8'h41, 1'b0);
      add_byte(2, 8'h42, 1'b0);
      add_byte(2, 8'h43, 1'b1);
      drive();
      build_model();
      n = 0;
      while (ngot < 4 && n < 30) begin step(); n++; end
      total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL single_busy_last: got %b want 1", busy_s); end
      step();
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy_s); end
      total++; if (grant_s !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant_s); end
      total++; if (ngot !== nexp) begin bad++; $display("FAIL single_len: got %0d want %0d", ngot, nexp); end
      for (int i = 0; i < nexp; i++) begin
         total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL single_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); end
      end
   endtask

   task automatic test_contention();
      do_reset();
      bus.TxReady = 1'b1;
      add_msg(0, 2);
      add_msg(3, 2);
      drive();
      build_model();
      run_done(100);
      total++; if (obs_g[0] !== 0) begin bad++; $display("FAIL cont_first: got %0d want 0", obs_g[0]); end
      total++; if (obs_g[1] !== 3) begin bad++; $display("FAIL cont_second: got %0d want 3", obs_g[1]); end
      total++; if (ngot !== nexp) begin bad++; $display("FAIL cont_len: got %0d want %0d", ngot, nexp); end
      for (int i = 0; i < nexp; i++) begin
         total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL cont_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); end
      end
   endtask

   task automatic test_fairness();
      clear();
      bus.TxReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         add_msg(0, 1);
         add_msg(1, 1);
      end
      drive();
      build_model();
      run_done(200);
      total++; if (nobs_g !== 6) begin bad++; $display("FAIL fair_count: got %0d want 6", nobs_g); end
      for (int i = 0; i < 6; i++) begin
         total++; if (obs_g[i] !== (i % 2)) begin bad++; $display("FAIL fair_grant[%0d]: got %0d want %0d", i, obs_g[i], i % 2); end
      end
      for (int i = 0; i < nexp; i++) begin
         total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL fair_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      clear();
      bus.TxReady = 1'b1;
      add_byte(1, 8'h5A, 1'b1);
      drive();
      build_model();
      n = 0;
      while (ngot < 1 && n < 10) begin step(); n++; end
      bus.TxReady = 1'b0;
      repeat (50) step();
      total++; if (ngot !== 1)      begin bad++; $display("FAIL bp_held: got %0d bytes want 1", ngot); end
      total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b want 1", busy_s); end
      bus.TxReady = 1'b1;
      n = 0;
      while (ngot < 2 && n < 5) begin step(); n++; end
      total++; if (abort_cnt !== 0)  begin bad++; $display("FAIL bp_abort: got %0d pulses want 0", abort_cnt); end
      total++; if (got[0] !== exp_b[0]) begin bad++; $display("FAIL bp_header: got %h want %h", got[0], exp_b[0]); end
      total++; if (got[1] !== 8'h5A) begin bad++; $display("FAIL bp_byte: got %h want 5a", got[1]); end
      run_done(20);
   endtask

   task automatic test_timeout();
      int n;
      int idle;
      clear();
      bus.TxReady = 1'b1;
      add_byte(1, 8'h11, 1'b0);
      drive();
      n = 0;
      while (nobs_g < 1 && n < 10) begin step(); n++; end
      total++; if (obs_g[0] !== 1) begin bad++; $display("FAIL to_grant1: got %0d want 1", obs_g[0]); end
      add_byte(2, 8'h22, 1'b1);
      drive();
      n = 0;
      while (ngot < 2 && n < 10) begin step(); n++; end
      idle = 0;
      abort_s = 1'b0;
      while (!abort_s && idle < 40) begin
         step();
         if (!abort_s) idle++;
      end
      total++; if (abort_s !== 1'b1) begin bad++; $display("FAIL to_abort: no pulse after %0d idle cycles", idle); end
      total++; if (idle !== TO) begin bad++; $display("FAIL to_idle_len: got %0d idle cycles want %0d", idle, TO); end
      step();
      total++; if (busy_s !== 1'b0)  begin bad++; $display("FAIL to_state_idle: busy got %b want 0", busy_s); end
      total++; if (abort_s !== 1'b0) begin bad++; $display("FAIL to_one_cycle: abort got %b want 0", abort_s); end
      run_done(20);
      total++; if (obs_g[1] !== 2)   begin bad++; $display("FAIL to_next_grant: got %0d want 2", obs_g[1]); end
      total++; if (got[2] !== 8'hF2) begin bad++; $display("FAIL to_hdr2: got %h want f2", got[2]); end
      total++; if (got[3] !== 8'h22) begin bad++; $display("FAIL to_byte2: got %h want 22", got[3]); end
      total++; if (abort_cnt !== 1)  begin bad++; $display("FAIL to_pulses: got %0d want 1", abort_cnt); end
      model_lg = 2;
   endtask

   task automatic test_reset_mid();
      int n;
      clear();
      bus.TxReady = 1'b1;
      add_msg(1, 4);
      drive();
      n = 0;
      while (ngot < 3 && n < 20) begin step(); n++; end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.Busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", bus.Busy); end
      total++; if (bus.TxValid !== 1'b0)  begin bad++; $display("FAIL mid_txvalid: got %b want 0", bus.TxValid); end
      total++; if (bus.ReqReady !== 4'h0) begin bad++; $display("FAIL mid_reqready: got %h want 0", bus.ReqReady); end
      total++; if (bus.Grant !== 2'd0)    begin bad++; $display("FAIL mid_grant: got %0d want 0", bus.Grant); end
      clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_lg  = NP - 1;
      prev_busy = 1'b0;
      add_msg(0, 1);
      add_msg(2, 1);
      drive();
      build_model();
      run_done(50);
      total++; if (obs_g[0] !== 0) begin bad++; $display("FAIL mid_priority: got %0d want 0", obs_g[0]); end
      for (int i = 0; i < nexp; i++) begin
         total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL mid_byte[%0d]: got %h want %h", i, got[i], exp_b[i]); end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         clear();
         rand_ready = 1'b1;
         for (int p = 0; p < NP; p++) begin
            int nm;
            nm = $urandom_range(0, 2);
            for (int m = 0; m < nm; m++) add_msg(p, $urandom_range(1, 4));
         end
         drive();
         build_model();
         run_done(1000);
         total++; if (ngot !== nexp) begin bad++; $display("FAIL rnd%0d_len: got %0d want %0d", it, ngot, nexp); end
         for (int i = 0; i < nexp; i++) begin
            total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL rnd%0d_byte[%0d]: got %h want %h", it, i, got[i], exp_b[i]); end
         end
         total++; if (nobs_g !== nexp_g) begin bad++; $display("FAIL rnd%0d_msgs: got %0d want %0d", it, nobs_g, nexp_g); end
         for (int i = 0; i < nexp_g; i++) begin
            total++; if (obs_g[i] !== exp_g[i]) begin bad++; $display("FAIL rnd%0d_grant[%0d]: got %0d want %0d", it, i, obs_g[i], exp_g[i]); end
         end
      end
      rand_ready  = 1'b0;
      bus.TxReady = 1'b1;
   endtask

   initial begin
      prev_busy = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
